// File: rtl/npc_pkg.sv
// Shared types for the next-PC sequencer: control encodings, FSM states, widths.
package npc_pkg;

    localparam int NPC_CTRL_W = 3;

    // Encodings 3'b110 and 3'b111 are illegal and have no enum member.
    typedef enum logic [NPC_CTRL_W-1:0] {
        SEQ    = 3'b000,
        BRANCH = 3'b001,
        JUMP   = 3'b010,
        CALL   = 3'b011,
        RET    = 3'b100,
        HALT   = 3'b101
    } npc_ctrl_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } npc_state_e;

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module npc_ras
    import npc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_top_idx;

    // r_ptr is the next free slot, so the top entry sits one below it.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(RAS_DEPTH));
    assign overflow  = push && full;
    assign underflow = pop && !push && empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!full)
                r_count <= r_count + CNT_W'(1);
        end else if (pop && !empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // NOTE: entries are not reset; r_count gates every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push && !clr)
            r_mem[r_ptr] <= push_data;
    end

endmodule

// File: rtl/next_pc_sequencer.sv
// Clocked, handshaked next-PC unit with RAS, halt/resume and flush.
// Optional macro NPS_ILLEGAL_TRAP_EN adds a sticky illegal_op output and traps illegal encodings to FLUSH_PC.
module next_pc_sequencer
    import npc_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          PC_STEP   = 1,
    parameter int          RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] FLUSH_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NPC_CTRL_W-1:0] npc_ctrl,
    input  logic [ADDR_W-1:0]     branch_target,
    input  logic [ADDR_W-1:0]     jump_target,
    input  logic                  flush,
    input  logic                  resume,
    output logic [ADDR_W-1:0]     pc,
`ifdef NPS_ILLEGAL_TRAP_EN
    output logic                  illegal_op,
`endif
    output logic                  pc_valid,
    output logic                  halted,
    output logic                  ras_overflow,
    output logic                  ras_underflow
);

    npc_state_e        r_state;
    npc_state_e        w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_npc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ras_top;
    logic              r_pc_valid;
    logic              r_ras_overflow;
    logic              r_ras_underflow;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_ras_ovf;
    logic              w_ras_unf;
    logic              w_illegal;
    npc_ctrl_e         w_ctrl;

    assign w_ctrl    = npc_ctrl_e'(npc_ctrl);
    assign w_illegal = (npc_ctrl > NPC_CTRL_W'(HALT));
    assign req_ready = reset_n && (r_state == S_RUN) && !flush;
    assign w_accept  = req_valid && req_ready;
    assign w_pc_inc  = r_pc + ADDR_W'(PC_STEP);
    assign w_push    = w_accept && (w_ctrl == CALL);
    assign w_pop     = w_accept && (w_ctrl == RET);

    npc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (flush),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full),
        .overflow  (w_ras_ovf),
        .underflow (w_ras_unf)
    );

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latches).
    always_comb begin
        w_npc        = w_pc_inc;
        w_next_state = r_state;
        case (w_ctrl)
            BRANCH:  w_npc = branch_target;
            JUMP:    w_npc = jump_target;
            CALL:    w_npc = jump_target;
            RET:     w_npc = w_ras_empty ? w_pc_inc : w_ras_top;
            default: w_npc = w_pc_inc;
        endcase
`ifdef NPS_ILLEGAL_TRAP_EN
        if (w_illegal)
            w_npc = FLUSH_PC;
`endif
        case (r_state)
            S_RUN:   if (w_accept && (w_ctrl == HALT)) w_next_state = S_HALT;
            S_HALT:  if (resume) w_next_state = S_RUN;
            default: w_next_state = S_RUN;
        endcase
        if (flush)
            w_next_state = S_RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_RUN;
            r_pc            <= RESET_PC;
            r_pc_valid      <= 1'b0;
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_pc_valid      <= flush || w_accept;
            r_ras_overflow  <= w_ras_ovf;
            r_ras_underflow <= w_ras_unf;
            if (flush)
                r_pc <= FLUSH_PC;
            else if (w_accept)
                r_pc <= w_npc;
        end
    end

`ifdef NPS_ILLEGAL_TRAP_EN
    logic r_illegal_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_illegal_op <= 1'b0;
        else if (flush)
            r_illegal_op <= 1'b0;
        else if (w_accept && w_illegal)
            r_illegal_op <= 1'b1;
    end

    assign illegal_op = r_illegal_op;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
`endif

    assign pc            = r_pc;
    assign pc_valid      = r_pc_valid;
    assign halted        = (r_state == S_HALT);
    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Scoreboard bench for next_pc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_next_pc_sequencer;

    localparam int          ADDR_W    = 8;
    localparam int          PC_STEP   = 1;
    localparam int          RAS_DEPTH = 4;
    localparam logic [7:0]  RESET_PC  = 8'h00;
    localparam logic [7:0]  FLUSH_PC  = 8'hA0;

    typedef struct {
        logic [7:0] pc;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] npc_ctrl = 3'd0;
    logic [7:0] branch_target = 8'd0;
    logic [7:0] jump_target = 8'd0;
    logic       flush = 1'b0;
    logic       resume = 1'b0;
    logic [7:0] pc;
    logic       pc_valid;
    logic       halted;
    logic       ras_overflow;
    logic       ras_underflow;
`ifdef NPS_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    logic [7:0] m_pc;
    logic [7:0] m_ras[$];

    always #5 clk = ~clk;

    next_pc_sequencer #(
        .ADDR_W    (ADDR_W),
        .PC_STEP   (PC_STEP),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_PC  (RESET_PC),
        .FLUSH_PC  (FLUSH_PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .npc_ctrl      (npc_ctrl),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .flush         (flush),
        .resume        (resume),
        .pc            (pc),
`ifdef NPS_ILLEGAL_TRAP_EN
        .illegal_op    (illegal_op),
`endif
        .pc_valid      (pc_valid),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: what one accepted request does to pc and the return stack.
    function automatic exp_t model_apply(input logic [2:0] c, input logic [7:0] bt, input logic [7:0] jt);
        exp_t e;
        logic [7:0] inc;
        inc   = m_pc + 8'(PC_STEP);
        e.ovf = 1'b0;
        e.unf = 1'b0;
        case (c)
            3'd1: m_pc = bt;
            3'd2: m_pc = jt;
            3'd3: begin
                m_ras.push_back(inc);
                if (m_ras.size() > RAS_DEPTH) begin
                    void'(m_ras.pop_front());
                    e.ovf = 1'b1;
                end
                m_pc = jt;
            end
            3'd4: begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    m_pc  = inc;
                    e.unf = 1'b1;
                end
            end
`ifdef NPS_ILLEGAL_TRAP_EN
            3'd6, 3'd7: m_pc = FLUSH_PC;
`endif
            default: m_pc = inc;
        endcase
        e.pc = m_pc;
        return e;
    endfunction

    task automatic issue(input logic [2:0] c, input logic [7:0] bt, input logic [7:0] jt);
        int n;
        @(negedge clk);
        npc_ctrl      = c;
        branch_target = bt;
        jump_target   = jt;
        req_valid     = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(model_apply(c, bt, jt));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_resume();
        @(negedge clk);
        check("halted_before_resume", 32'(halted), 32'd1);
        check("ready_in_halt", 32'(req_ready), 32'd0);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("halted_after_resume", 32'(halted), 32'd0);
        check("ready_after_resume", 32'(req_ready), 32'd1);
        check("pc_after_resume", 32'(pc), 32'(m_pc));
    endtask

    task automatic do_flush(input logic [7:0] bt);
        exp_t e;
        @(negedge clk);
        flush         = 1'b1;
        req_valid     = 1'b1;
        npc_ctrl      = 3'd1;
        branch_target = bt;
        #1 check("ready_during_flush", 32'(req_ready), 32'd0);
        m_pc = FLUSH_PC;
        m_ras.delete();
        e.pc = FLUSH_PC; e.ovf = 1'b0; e.unf = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 flush = 1'b0;
        req_valid = 1'b0;
    endtask

    // Monitor: every pc_valid pulse must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (pc_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pc_valid", 32'(pc_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc", 32'(pc), 32'(e.pc));
                        check("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
                        check("ras_underflow", 32'(ras_underflow), 32'(e.unf));
                    end
                end else begin
                    check("stray_flags", 32'({ras_overflow, ras_underflow}), 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] c;
        m_pc = RESET_PC;

        // Reset values, then three sequential steps.
        #12;
        check("reset_pc", 32'(pc), 32'(RESET_PC));
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("ready_after_reset", 32'(req_ready), 32'd1);
        check("pc_valid_after_reset", 32'(pc_valid), 32'd0);
        repeat (3) issue(3'd0, 8'h00, 8'h00);

        // Increment wrap.
        issue(3'd1, 8'hFF, 8'h00);
        issue(3'd0, 8'h00, 8'h00);

        // Call / return pair.
        issue(3'd1, 8'h10, 8'h00);
        issue(3'd3, 8'h00, 8'h40);
        issue(3'd4, 8'h00, 8'h00);
        issue(3'd4, 8'h00, 8'h00);

        // Five calls into a four-deep stack, then five returns.
        for (int i = 0; i < 5; i++) issue(3'd3, 8'h00, 8'(8'h50 + 8'(i * 16)));
        for (int i = 0; i < 5; i++) issue(3'd4, 8'h00, 8'h00);

        // Halt with a held branch that must stall until resume.
        issue(3'd1, 8'h20, 8'h00);
        issue(3'd5, 8'h00, 8'h00);
        @(negedge clk);
        npc_ctrl      = 3'd1;
        branch_target = 8'h33;
        req_valid     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_halted", 32'(halted), 32'd1);
            check("stall_pc", 32'(pc), 32'h21);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_ready", 32'(req_ready), 32'd1);
        check("resume_pc", 32'(pc), 32'h21);
        exp_q.push_back(model_apply(3'd1, 8'h33, 8'h00));
        @(posedge clk);
        #1 req_valid = 1'b0;

        // Flush beats a simultaneous branch and clears the stack.
        issue(3'd3, 8'h00, 8'h60);
        do_flush(8'h77);
        issue(3'd4, 8'h00, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) do_flush(8'($urandom));
            c = 3'($urandom_range(0, 7));
            issue(c, 8'($urandom), 8'($urandom));
            if (c == 3'd5) do_resume();
        end

        // Reset asserted while halted with a stalled request.
        issue(3'd5, 8'h00, 8'h00);
        @(negedge clk);
        npc_ctrl  = 3'd2;
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_pc", 32'(pc), 32'(RESET_PC));
        check("async_reset_halted", 32'(halted), 32'd0);
        check("async_reset_ready", 32'(req_ready), 32'd0);
        check("async_reset_pc_valid", 32'(pc_valid), 32'd0);
        check("pending_queue_empty", 32'(exp_q.size()), 32'd0);
        req_valid = 1'b0;
        m_pc = RESET_PC;
        m_ras.delete();
        @(negedge clk);
        reset_n = 1'b1;
        issue(3'd4, 8'h00, 8'h00);
        issue(3'd0, 8'h00, 8'h00);

        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
